// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared types for the fetch/decode front end
package rv32i_types;

  // One buffered fetch result: instruction word plus its PC
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } iq_entry_t;

endpackage

// File: rtl/instruction_queue.sv
// rtl/instruction_queue.sv - circular instruction FIFO between fetch and decode
module instruction_queue
  import rv32i_types::*;
#(
  parameter int iq_size       = 8,
  parameter int iq_index_bits = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_valid,
  input  logic [31:0]              fetch_instr,
  input  logic [31:0]              fetch_pc,
  output logic                     iq_full,
  output logic [31:0]              instruction_iq_head,
  output logic [31:0]              PC_iq_head,
  output logic                     load_dec_iq,
  input  logic                     full_dec,
  input  logic                     flush,
  output logic [iq_index_bits:0]   iq_count,
  output logic [31:0]              stall_cycles
);

  localparam logic [iq_index_bits:0]   FullCount = (iq_index_bits + 1)'(iq_size);
  localparam logic [iq_index_bits:0]   CountOne  = (iq_index_bits + 1)'(1);
  localparam logic [iq_index_bits-1:0] PtrOne    = (iq_index_bits)'(1);

  iq_entry_t                mem_q [iq_size];
  logic [iq_index_bits-1:0] head_q, head_d;
  logic [iq_index_bits-1:0] tail_q, tail_d;
  logic [iq_index_bits:0]   count_q, count_d;
  logic [31:0]              stall_q, stall_d;
  logic                     push, pop;
  iq_entry_t                head_entry;
  iq_entry_t                fetch_entry;

  // Full/valid come only from registered occupancy, so full_dec never loops back into load_dec_iq
  assign iq_full     = (count_q == FullCount);
  assign load_dec_iq = (count_q != '0);
  assign push        = fetch_valid && !iq_full;
  assign pop         = load_dec_iq && !full_dec;

  assign fetch_entry = '{instr: fetch_instr, pc: fetch_pc};
  assign head_entry  = mem_q[head_q];

  // Head outputs read the oldest slot directly and are zeroed when empty
  always_comb begin
    instruction_iq_head = '0;
    PC_iq_head          = '0;
    if (load_dec_iq) begin
      instruction_iq_head = head_entry.instr;
      PC_iq_head          = head_entry.pc;
    end
  end

  assign iq_count     = count_q;
  assign stall_cycles = stall_q;

  // Next-state for pointers, occupancy and stall counter; flush outranks push and pop
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    stall_d = stall_q;
    if (load_dec_iq && full_dec) begin
      stall_d = stall_q + 32'd1;
    end
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        tail_d = tail_q + PtrOne;
      end
      if (pop) begin
        head_d = head_q + PtrOne;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CountOne;
        2'b01:   count_d = count_q - CountOne;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      stall_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      stall_q <= stall_d;
    end
  end

  // Entry storage; contents are left untouched by reset and flush
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) begin
      mem_q[tail_q] <= fetch_entry;
    end
  end

endmodule

// File: tb/tb_instruction_queue.sv
// tb/tb_instruction_queue.sv - scoreboard testbench for instruction_queue
module tb_instruction_queue;

  logic        clk;
  logic        rst;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic        iq_full;
  logic [31:0] instruction_iq_head;
  logic [31:0] PC_iq_head;
  logic        load_dec_iq;
  logic        full_dec;
  logic        flush;
  logic [3:0]  iq_count;
  logic [31:0] stall_cycles;

  int          errors;
  int          checks;
  logic [63:0] sb[$];
  int          mcount;
  logic [31:0] mstall;

  instruction_queue #(.iq_size(8), .iq_index_bits(3)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .fetch_valid         (fetch_valid),
    .fetch_instr         (fetch_instr),
    .fetch_pc            (fetch_pc),
    .iq_full             (iq_full),
    .instruction_iq_head (instruction_iq_head),
    .PC_iq_head          (PC_iq_head),
    .load_dec_iq         (load_dec_iq),
    .full_dec            (full_dec),
    .flush               (flush),
    .iq_count            (iq_count),
    .stall_cycles        (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle of stimulus; pops are checked against the scoreboard front before the edge
  task automatic drive_cycle(input logic fv, input logic [31:0] instr, input logic [31:0] pc,
                             input logic fd, input logic fl);
    logic        mpush;
    logic        mpop;
    logic [63:0] exp;
    fetch_valid = fv;
    fetch_instr = instr;
    fetch_pc    = pc;
    full_dec    = fd;
    flush       = fl;
    #3;
    mpush = fv && (mcount < 8);
    mpop  = (mcount != 0) && !fd;
    if (mpop) begin
      exp = sb.pop_front();
      checks++;
      if ({instruction_iq_head, PC_iq_head} !== exp) begin
        errors++;
        $display("FAIL pop_order: got %h/%h expected %h/%h",
                 instruction_iq_head, PC_iq_head, exp[63:32], exp[31:0]);
      end
    end
    if ((mcount != 0) && fd) mstall = mstall + 32'd1;
    if (fl) begin
      sb.delete();
      mcount = 0;
    end else begin
      if (mpush) sb.push_back({instr, pc});
      mcount = mcount + int'(mpush) - int'(mpop);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 16 && mcount != 0; i++) drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    fetch_valid = 1'b0;
    full_dec    = 1'b0;
  endtask

  task automatic model_reset();
    sb.delete();
    mcount = 0;
    mstall = 32'd0;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    fetch_valid = 1'b1;
    fetch_instr = 32'hDEAD_BEEF;
    fetch_pc    = 32'h44;
    full_dec    = 1'b0;
    flush       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst         = 1'b0;
    fetch_valid = 1'b0;
    model_reset();
    #2;
    checks++;
    if (load_dec_iq !== 1'b0) begin errors++; $display("FAIL reset_load: got %b expected 0", load_dec_iq); end
    checks++;
    if (iq_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", iq_count); end
    checks++;
    if (iq_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", iq_full); end
    checks++;
    if ({instruction_iq_head, PC_iq_head} !== 64'h0) begin
      errors++; $display("FAIL reset_head: got %h/%h expected 0/0", instruction_iq_head, PC_iq_head);
    end
    checks++;
    if (stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_stall: got %0d expected 0", stall_cycles); end
    @(posedge clk);
    #1;
    drive_cycle(1'b1, 32'h0000_0013, 32'h60, 1'b1, 1'b0);
    checks++;
    if (load_dec_iq !== 1'b1) begin errors++; $display("FAIL first_push_load: got %b expected 1", load_dec_iq); end
    checks++;
    if (instruction_iq_head !== 32'h13 || PC_iq_head !== 32'h60) begin
      errors++; $display("FAIL first_push_head: got %h/%h expected 00000013/00000060", instruction_iq_head, PC_iq_head);
    end
    checks++;
    if (iq_count !== 4'd1) begin errors++; $display("FAIL first_push_count: got %0d expected 1", iq_count); end
    drain();
  endtask

  task automatic test_fill_wrap();
    for (int i = 0; i < 8; i++) drive_cycle(1'b1, 32'h1000 + i, 32'(i * 4), 1'b1, 1'b0);
    checks++;
    if (iq_full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b expected 1", iq_full); end
    checks++;
    if (iq_count !== 4'd8) begin errors++; $display("FAIL fill_count: got %0d expected 8", iq_count); end
    drive_cycle(1'b1, 32'h1008, 32'h20, 1'b1, 1'b0);
    checks++;
    if (iq_count !== 4'd8) begin errors++; $display("FAIL ninth_push: got %0d expected 8", iq_count); end
    checks++;
    if (stall_cycles !== mstall) begin errors++; $display("FAIL fill_stall: got %0d expected %0d", stall_cycles, mstall); end
    for (int i = 0; i < 20; i++) drive_cycle(1'b1, 32'h2000 + i, 32'h100 + 32'(i * 4), 1'b0, 1'b0);
    checks++;
    if (iq_count !== 4'(mcount)) begin errors++; $display("FAIL wrap_count: got %0d expected %0d", iq_count, mcount); end
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 32'h3000 + i, 32'h300 + 32'(i * 4), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1, 32'h3100 + i, 32'h400 + 32'(i * 4), 1'b0, 1'b0);
      checks++;
      if (iq_count !== 4'd3) begin errors++; $display("FAIL simul_count: got %0d expected 3", iq_count); end
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [31:0] s0;
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, 32'h4000 + i, 32'h20 + 32'(i * 4), 1'b1, 1'b0);
    drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    s0 = mstall;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      checks++;
      if (PC_iq_head !== 32'h24) begin errors++; $display("FAIL bp_hold: got %h expected 00000024", PC_iq_head); end
    end
    checks++;
    if (stall_cycles !== s0 + 32'd3) begin errors++; $display("FAIL bp_stall: got %0d expected %0d", stall_cycles, s0 + 32'd3); end
    checks++;
    if (iq_count !== 4'd3) begin errors++; $display("FAIL bp_count: got %0d expected 3", iq_count); end
    drain();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, 32'h5000 + i, 32'h500 + 32'(i * 4), 1'b1, 1'b0);
    checks++;
    if (iq_count !== 4'd5) begin errors++; $display("FAIL flush_pre_count: got %0d expected 5", iq_count); end
    drive_cycle(1'b1, 32'h5100, 32'h100, 1'b1, 1'b1);
    checks++;
    if (iq_count !== 4'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", iq_count); end
    checks++;
    if (load_dec_iq !== 1'b0) begin errors++; $display("FAIL flush_load: got %b expected 0", load_dec_iq); end
    checks++;
    if (PC_iq_head !== 32'h0) begin errors++; $display("FAIL flush_head: got %h expected 0", PC_iq_head); end
    drive_cycle(1'b1, 32'h5200, 32'h200, 1'b1, 1'b0);
    checks++;
    if (PC_iq_head !== 32'h200 || instruction_iq_head !== 32'h5200) begin
      errors++; $display("FAIL flush_refill: got %h/%h expected 00005200/00000200", instruction_iq_head, PC_iq_head);
    end
    checks++;
    if (iq_count !== 4'd1) begin errors++; $display("FAIL flush_refill_count: got %0d expected 1", iq_count); end
    drain();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) drive_cycle(1'b1, 32'h6000 + i, 32'h600 + 32'(i * 4), 1'b1, 1'b0);
    checks++;
    if (iq_count !== 4'd6) begin errors++; $display("FAIL mid_pre_count: got %0d expected 6", iq_count); end
    rst         = 1'b1;
    fetch_valid = 1'b1;
    full_dec    = 1'b1;
    @(posedge clk);
    #1;
    rst         = 1'b0;
    fetch_valid = 1'b0;
    full_dec    = 1'b0;
    model_reset();
    #2;
    checks++;
    if (iq_count !== 4'd0 || load_dec_iq !== 1'b0 || iq_full !== 1'b0) begin
      errors++; $display("FAIL mid_reset_state: got count=%0d load=%b full=%b expected 0/0/0", iq_count, load_dec_iq, iq_full);
    end
    checks++;
    if ({instruction_iq_head, PC_iq_head} !== 64'h0) begin
      errors++; $display("FAIL mid_reset_head: got %h/%h expected 0/0", instruction_iq_head, PC_iq_head);
    end
    checks++;
    if (stall_cycles !== 32'd0) begin errors++; $display("FAIL mid_reset_stall: got %0d expected 0", stall_cycles); end
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    mcount      = 0;
    mstall      = 32'd0;
    rst         = 1'b1;
    fetch_valid = 1'b0;
    fetch_instr = 32'h0;
    fetch_pc    = 32'h0;
    full_dec    = 1'b0;
    flush       = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_fill_wrap();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_queue.md
# instruction_queue

Circular FIFO between the fetch unit and the decoder that buffers fetched `{instruction, PC}` pairs. It presents the oldest entry to the decoder on `instruction_iq_head`/`PC_iq_head`, with `load_dec_iq` as the valid signal. The decoder's `full_dec` back-pressures the queue. A flush from branch resolution empties the queue in one cycle.

## Interface
Parameters:
- `iq_size`, default 8: number of entries; must be a power of 2.
- `iq_index_bits`, default 3: log2(`iq_size`).

Ports:
- `clk`  in  1  system clock; one clock domain, all state on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `fetch_valid`  in  1  fetch presents an instruction this cycle.
- `fetch_instr`  in  32  fetched instruction word.
- `fetch_pc`  in  32  PC of `fetch_instr`.
- `iq_full`  out  1  queue cannot accept a push this cycle.
- `instruction_iq_head`  out  32  oldest instruction; 0 when empty.
- `PC_iq_head`  out  32  PC of oldest instruction; 0 when empty.
- `load_dec_iq`  out  1  head entry valid (queue non-empty).
- `full_dec`  in  1  decoder cannot consume the head this cycle.
- `flush`  in  1  discard all entries (mispredict/redirect).
- `iq_count`  out  iq_index_bits+1  current occupancy.
- `stall_cycles`  out  32  count of cycles with `load_dec_iq && full_dec`.

## Operation
- Storage: `iq_size` entries of `iq_entry_t`. Pointers: `head` and `tail`, each `iq_index_bits` wide. Occupancy: `count`, `iq_index_bits+1` wide.
- Push = `fetch_valid && !iq_full`. The entry is written at `tail`, then `tail` increments and wraps modulo `iq_size`.
- Pop = `load_dec_iq && !full_dec`. Then `head` increments with wrap.
- `count` next value = count + push − pop. A simultaneous push and pop leaves `count` unchanged.
- `iq_full` = (count == iq_size), from registered state only. A push is refused when full even if a pop occurs in the same cycle.
- `load_dec_iq` = (count != 0).
- Head outputs read combinationally from `mem[head]`. Both head outputs are forced to 0 when `count == 0`.
- `full_dec` is a combinational input from the decoder. The queue must not feed it back combinationally into `load_dec_iq`, so there is no loop.
- Flush has priority over push and pop in the same cycle. Next state: head = tail = count = 0. The same-cycle push is dropped. Storage contents are not cleared.
- An illegal opcode at the head still pops, because the decoder does not assert `full_dec` for it.
- `stall_cycles` increments by 1 each cycle `load_dec_iq && full_dec`, wraps at 2^32, and is not affected by `flush`.

## Timing
- Reset values: head/tail/count = 0, `load_dec_iq` = 0, `iq_full` = 0, `instruction_iq_head` = 0, `PC_iq_head` = 0, `iq_count` = 0, `stall_cycles` = 0. Reset overrides flush, push and pop.
- Push-to-visible latency is 1 cycle. An entry pushed at edge N appears on the head outputs after edge N; there is no bypass from empty.
- Pop takes effect at the edge. The next entry is presented in the following cycle, giving throughput of 1 instruction per cycle when the queue is non-empty.
- Flush at edge N: `load_dec_iq` = 0 after edge N. A push in cycle N+1 is visible after edge N+1.
- Throughput of 1 per cycle is sustained at full occupancy only when a pop frees an entry in the previous cycle. When full, `iq_full` deasserts the cycle after a pop.

## Structure
- `iq_entry_t` (packed struct `{logic [31:0] instr; logic [31:0] pc;}`) goes in `rv32i_types`.
- Single module, no sub-module. Storage is a flop array indexed by pointers.

## Test plan
- **Reset and empty:** assert `rst` for 2 cycles, with `fetch_valid` = 1 during reset → no entries; after release, push `0x00000013` @ PC `0x60` → `load_dec_iq` = 1, head = `0x00000013`/`0x60` one cycle later, `iq_count` = 1.
- **Fill and wrap:** push 8 entries with PCs `0x0`–`0x1C` while `full_dec` = 1 → `iq_full` = 1, 9th push ignored, `stall_cycles` increments each cycle; release `full_dec` and push concurrently for 20 cycles → PCs are popped in strict order across the pointer wrap.
- **Simultaneous push/pop:** at `count` = 3, push and pop together for 5 cycles → `iq_count` stays 3, order preserved.
- **Back-pressure mid-stream:** pulse `full_dec` for 3 cycles with head PC `0x24` → head holds `0x24` for those 3 cycles, `stall_cycles` += 3, no entry lost.
- **Flush with concurrent push:** `count` = 5, assert `flush` and `fetch_valid` (PC `0x100`) → next cycle `count` = 0, `load_dec_iq` = 0, `0x100` is not enqueued; push PC `0x200` → it becomes the head.
- **Reset mid-operation:** `count` = 6 → assert `rst` → all outputs return to reset values, including `stall_cycles`.
